// File: rtl/chdr_conv_arbiter_pkg.sv
// Shared types and constants for the CHDR converter arbiter.
package chdr_conv_arbiter_pkg;

    // Config word layout: [16] = enable, [15:0] = destination SID
    localparam int ENABLE_BIT = 16;
    localparam int DEST_MSB   = 15;
    localparam int CFG_W      = ENABLE_BIT + 1;

    localparam logic [7:0] DEFAULT_CONV_ADDR = 8'd89;

    typedef logic [CFG_W-1:0] cfg_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_CFG,
        ST_SETTLE,
        ST_PASS
    } state_t;

    // Zero-extends a config word to the 32-bit settings bus
    function automatic logic [31:0] cfg_to_word(input cfg_t c);
        return {{(32-CFG_W){1'b0}}, c};
    endfunction

endpackage

// File: rtl/chdr_conv_arbiter_if.sv
// CHDR AXI-stream style link: data, framing and valid/ready handshake.
interface chdr_conv_arbiter_if;
    logic [63:0] tdata;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/chdr_conv_arbiter_regs.sv
// Per-port converter config words and tracking of the word the converter
// currently holds. "Loaded" starts invalid so the first grant always
// programs the converter, even if the port config happens to be zero.
module chdr_conv_arbiter_regs
    import chdr_conv_arbiter_pkg::*;
#(
    parameter logic [7:0] BASE = 8'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        set_stb_i,
    input  logic [7:0]  set_addr_i,
    input  logic [31:0] set_data_i,
    input  logic        sel_i,
    input  logic        load_i,
    output cfg_t        sel_cfg_o,
    output logic        cfg_match_o
);
    localparam logic [7:0] ADDR0 = BASE;
    localparam logic [7:0] ADDR1 = BASE + 8'd1;

    cfg_t cfg0_q, cfg0_d;
    cfg_t cfg1_q, cfg1_d;
    cfg_t loaded_q, loaded_d;
    logic loaded_vld_q, loaded_vld_d;
    logic unused_set_bits;

    assign unused_set_bits = ^set_data_i[31:CFG_W];

    // Next-state for config words and the loaded-config shadow
    always_comb begin
        cfg0_d       = cfg0_q;
        cfg1_d       = cfg1_q;
        loaded_d     = loaded_q;
        loaded_vld_d = loaded_vld_q;
        if (set_stb_i && set_addr_i == ADDR0) cfg0_d = set_data_i[CFG_W-1:0];
        if (set_stb_i && set_addr_i == ADDR1) cfg1_d = set_data_i[CFG_W-1:0];
        if (load_i) begin
            loaded_d     = sel_cfg_o;
            loaded_vld_d = 1'b1;
        end
    end

    // Register state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg0_q       <= '0;
            cfg1_q       <= '0;
            loaded_q     <= '0;
            loaded_vld_q <= 1'b0;
        end else begin
            cfg0_q       <= cfg0_d;
            cfg1_q       <= cfg1_d;
            loaded_q     <= loaded_d;
            loaded_vld_q <= loaded_vld_d;
        end
    end

    assign sel_cfg_o   = sel_i ? cfg1_q : cfg0_q;
    assign cfg_match_o = loaded_vld_q && (loaded_q == sel_cfg_o);

endmodule

// File: rtl/chdr_conv_arbiter.sv
// Packet-boundary round-robin arbiter sharing one CHDR converter between
// two requesters, reprogramming the converter between packets when needed.
//
// state  | meaning
// IDLE   | no packet granted; pick next requester
// DRAIN  | wait for all converted packets to leave the converter
// CFG    | one-cycle settings write of the granted port's config
// SETTLE | idle gap so the converter absorbs the new config
// PASS   | granted port streams straight into the converter
module chdr_conv_arbiter
    import chdr_conv_arbiter_pkg::*;
#(
    parameter logic [7:0]  BASE          = 8'd0,
    parameter logic [7:0]  CONV_ADDR     = DEFAULT_CONV_ADDR,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       set_stb,
    input  logic [7:0]                 set_addr,
    input  logic [31:0]                set_data,
    chdr_conv_arbiter_if.slave         in0,
    chdr_conv_arbiter_if.slave         in1,
    chdr_conv_arbiter_if.master        conv_i,
    output logic                       conv_set_stb,
    output logic [7:0]                 conv_set_addr,
    output logic [31:0]                conv_set_data,
    input  logic                       conv_o_tlast,
    input  logic                       conv_o_tvalid,
    input  logic                       conv_o_tready,
    output logic                       grant,
    output logic                       busy
);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic       grant_q, grant_d;
    logic [3:0] settle_q, settle_d;
    logic [1:0] outst_q, outst_d;

    logic req_any, pick, cfg_sel, cfg_match;
    logic g_tvalid, g_tlast;
    logic in_hs_last, out_hs_last;
    cfg_t sel_cfg;

    // Both requesting: alternate away from the last grant; else take the one asking
    assign req_any = in0.tvalid | in1.tvalid;
    assign pick    = (in0.tvalid & in1.tvalid) ? ~grant_q : in1.tvalid;
    assign cfg_sel = (state_q == ST_IDLE) ? pick : grant_q;

    assign g_tvalid = grant_q ? in1.tvalid : in0.tvalid;
    assign g_tlast  = grant_q ? in1.tlast  : in0.tlast;

    assign in_hs_last  = conv_i.tvalid & conv_i.tready & conv_i.tlast;
    assign out_hs_last = conv_o_tvalid & conv_o_tready & conv_o_tlast;

    chdr_conv_arbiter_regs #(
        .BASE (BASE)
    ) u_regs (
        .clk         (clk),
        .reset_n     (reset_n),
        .set_stb_i   (set_stb),
        .set_addr_i  (set_addr),
        .set_data_i  (set_data),
        .sel_i       (cfg_sel),
        .load_i      (state_q == ST_CFG),
        .sel_cfg_o   (sel_cfg),
        .cfg_match_o (cfg_match)
    );

    // Packets inside the converter: entered minus completed, saturating
    always_comb begin
        outst_d = outst_q;
        if (in_hs_last && !out_hs_last && outst_q != 2'd3) outst_d = outst_q + 2'd1;
        if (!in_hs_last && out_hs_last && outst_q != 2'd0) outst_d = outst_q - 2'd1;
    end

    // Next-state and outputs
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        settle_d      = settle_q;
        conv_set_stb  = 1'b0;
        conv_set_addr = '0;
        conv_set_data = '0;
        conv_i.tdata  = '0;
        conv_i.tlast  = 1'b0;
        conv_i.tvalid = 1'b0;
        in0.tready    = 1'b0;
        in1.tready    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    grant_d = pick;
                    state_d = cfg_match ? ST_PASS : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (outst_q == 2'd0) state_d = ST_CFG;
            end
            ST_CFG: begin
                conv_set_stb  = 1'b1;
                conv_set_addr = CONV_ADDR;
                conv_set_data = cfg_to_word(sel_cfg);
                settle_d      = SETTLE_LOAD;
                state_d       = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == 4'd0) state_d = ST_PASS;
                else                  settle_d = settle_q - 4'd1;
            end
            ST_PASS: begin
                if (grant_q) begin
                    conv_i.tdata  = in1.tdata;
                    conv_i.tlast  = in1.tlast;
                    conv_i.tvalid = in1.tvalid;
                    in1.tready    = conv_i.tready;
                end else begin
                    conv_i.tdata  = in0.tdata;
                    conv_i.tlast  = in0.tlast;
                    conv_i.tvalid = in0.tvalid;
                    in0.tready    = conv_i.tready;
                end
                if (g_tvalid && conv_i.tready && g_tlast) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; port 1 counts as last granted so port 0 wins first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= 1'b1;
            settle_q <= '0;
            outst_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            settle_q <= settle_d;
            outst_q  <= outst_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != ST_IDLE);

endmodule
